// File: rtl/bru_pkg.sv
// Shared types for the branch resolve unit: funct3 codes, 2-bit counter states,
// the BTB entry layout and the taken/counter helper functions.
package bru_pkg;

  // Widest address the BTB entry layout can hold; instantiate with XLEN <= XLEN_MAX.
  localparam int XLEN_MAX = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  typedef struct packed {
    logic                valid;
    logic [XLEN_MAX-1:0] tag;
    logic [XLEN_MAX-1:0] target;
    ctr_t                ctr;
  } btb_entry_t;

  function automatic ctr_t ctr_inc(input ctr_t c);
    ctr_t n;
    n = (c == ST) ? ST : ctr_t'(c + 2'd1);
    return n;
  endfunction

  function automatic ctr_t ctr_dec(input ctr_t c);
    ctr_t n;
    n = (c == SNT) ? SNT : ctr_t'(c - 2'd1);
    return n;
  endfunction

  // The two reserved funct3 codes (010/011) resolve as never taken.
  function automatic logic branch_taken(input logic [2:0] f3, input logic less,
                                        input logic equal);
    logic t;
    t = 1'b0;
    case (f3)
      F3_BEQ:          t = equal;
      F3_BNE:          t = ~equal;
      F3_BLT, F3_BLTU: t = less;
      F3_BGE, F3_BGEU: t = ~less;
      default:         t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/bru_btb.sv
// Direct-mapped branch target buffer with 2-bit counters: combinational lookup
// of the registered array (read-before-write) and a single training port.
module bru_btb
  import bru_pkg::*;
#(
  parameter int BTB_DEPTH = 16,
  parameter int XLEN      = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_en,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic            upd_jump,
  input  logic [XLEN-1:0] upd_target
);

  localparam int IDX_W = $clog2(BTB_DEPTH);

  btb_entry_t mem [BTB_DEPTH];

  logic [IDX_W-1:0]    lk_idx;
  logic [IDX_W-1:0]    up_idx;
  logic [XLEN_MAX-1:0] lk_tag;
  logic [XLEN_MAX-1:0] up_tag;
  btb_entry_t          lk_ent;
  btb_entry_t          up_ent;
  logic                lk_hit;
  logic                up_hit;
  logic                unused_pc_lsbs;

  // Instructions are word aligned, so the low two PC bits carry no information.
  assign unused_pc_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign lk_tag = XLEN_MAX'(lookup_pc[XLEN-1:IDX_W+2]);
  assign up_tag = XLEN_MAX'(upd_pc[XLEN-1:IDX_W+2]);

  assign lk_ent = mem[lk_idx];
  assign up_ent = mem[up_idx];
  assign lk_hit = lk_ent.valid && (lk_ent.tag == lk_tag);
  assign up_hit = up_ent.valid && (up_ent.tag == up_tag);

  assign pred_taken  = lk_hit & lk_ent.ctr[1];
  assign pred_target = lk_hit ? lk_ent.target[XLEN-1:0] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        mem[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
      end
    end else if (upd_en) begin
      if (up_hit) begin
        if (upd_jump) begin
          mem[up_idx].ctr <= ST;
        end else if (upd_taken) begin
          mem[up_idx].ctr <= ctr_inc(up_ent.ctr);
        end else begin
          mem[up_idx].ctr <= ctr_dec(up_ent.ctr);
        end
        if (upd_taken) begin
          mem[up_idx].target <= XLEN_MAX'(upd_target);
        end
      end else if (upd_taken) begin
        // Taken miss allocates, evicting whatever shared the index.
        mem[up_idx] <= '{valid:  1'b1,
                         tag:    up_tag,
                         target: XLEN_MAX'(upd_target),
                         ctr:    (upd_jump ? ST : WT)};
      end
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution, mispredict redirect/flush and BTB ownership.
// Optional macro BRU_PERF_CNT_EN adds resolve and mispredict event counters.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int BTB_DEPTH = 16,
  parameter int XLEN      = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [XLEN-1:0] i_if_pc,
  output logic            o_if_pred_taken,
  output logic [XLEN-1:0] o_if_pred_target,
  input  logic            i_ex_valid,
  input  logic            i_ex_stall,
  input  logic            i_ex_is_branch,
  input  logic            i_ex_is_jump,
  input  logic [2:0]      i_ex_funct3,
  input  logic [XLEN-1:0] i_ex_pc,
  input  logic [XLEN-1:0] i_ex_target,
  input  logic            i_ex_pred_taken,
  input  logic [XLEN-1:0] i_ex_pred_target,
  input  logic            i_br_less,
  input  logic            i_br_equal,
  output logic            o_br_un,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_flush
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0]     o_br_cnt,
  output logic [31:0]     o_mispred_cnt
`endif
);

  logic            resolve;
  logic            taken;
  logic            target_wrong;
  logic            mispredict;
  logic [XLEN-1:0] fallthrough_pc;
  logic            btb_pred_taken;
  logic [XLEN-1:0] btb_pred_target;

  assign resolve = i_ex_valid & ~i_ex_stall & (i_ex_is_branch | i_ex_is_jump);

  // A jump overrides any branch decode that happens to be asserted with it.
  assign taken = i_ex_is_jump | branch_taken(i_ex_funct3, i_br_less, i_br_equal);

  assign target_wrong   = taken & i_ex_pred_taken & (i_ex_pred_target != i_ex_target);
  assign mispredict     = resolve & ((taken != i_ex_pred_taken) | target_wrong);
  assign fallthrough_pc = i_ex_pc + XLEN'(4);

  // Every output is forced low while reset is held, even with a resolve in EX.
  assign o_redirect       = i_rst_n & mispredict;
  assign o_flush          = o_redirect;
  assign o_redirect_pc    = o_redirect ? (taken ? i_ex_target : fallthrough_pc) : '0;
  assign o_br_un          = i_rst_n & i_ex_funct3[1];
  assign o_if_pred_taken  = i_rst_n & btb_pred_taken;
  assign o_if_pred_target = i_rst_n ? btb_pred_target : '0;

  bru_btb #(
    .BTB_DEPTH (BTB_DEPTH),
    .XLEN      (XLEN)
  ) u_btb (
    .clk         (i_clk),
    .rst_n       (i_rst_n),
    .lookup_pc   (i_if_pc),
    .pred_taken  (btb_pred_taken),
    .pred_target (btb_pred_target),
    .upd_en      (resolve),
    .upd_pc      (i_ex_pc),
    .upd_taken   (taken),
    .upd_jump    (i_ex_is_jump),
    .upd_target  (i_ex_target)
  );

`ifdef BRU_PERF_CNT_EN
  logic [31:0] br_cnt;
  logic [31:0] mispred_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      br_cnt      <= '0;
      mispred_cnt <= '0;
    end else begin
      if (resolve) begin
        br_cnt <= br_cnt + 32'd1;
      end
      if (mispredict) begin
        mispred_cnt <= mispred_cnt + 32'd1;
      end
    end
  end

  assign o_br_cnt      = br_cnt;
  assign o_mispred_cnt = mispred_cnt;
`endif

endmodule
